uart_recv: RTL
==============

UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, baud rate.
REQ-003 SHALL derive BPS_CNT = CLK_FREQ/UART_BPS (integer) and HALF = BPS_CNT/2; defaults give 434 and 217.
REQ-004 SHALL have port sys_clk, input, 1, system clock; all logic on the rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port uart_rxd, input, 1, asynchronous serial line; idles high.
REQ-007 SHALL have port uart_data, output, 8, last good received byte, LSB first on the line.
REQ-008 SHALL have port uart_done, output, 1, one-cycle pulse when uart_data is updated.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port uart_rx_busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass uart_rxd through a 2-FF synchronizer (rx_s) before any use; a third register (rx_d) SHALL give edge detect.
REQ-012 SHALL detect a start edge when rx_d=1 and rx_s=0 while in IDLE.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 SHALL use a 16-bit bit-period counter clk_cnt, cleared on entry to START, incrementing each cycle, wrapping BPS_CNT-1 -> 0.
REQ-015 SHALL sample each bit by majority of 3 values of rx_s at clk_cnt = HALF-1, HALF, HALF+1; the decision SHALL take effect at clk_cnt = HALF+1.
REQ-016 IDLE -> START on start edge.
REQ-017 START: majority 0 at mid-bit -> continue; majority 1 -> IDLE (glitch rejection), no output pulse.
REQ-018 START -> DATA at the clk_cnt wrap following a valid start sample.
REQ-019 DATA SHALL shift 8 majority samples into a shift register, LSB first, using a 3-bit bit index; after the 8th sample and the following wrap -> STOP.
REQ-020 STOP: majority 1 at mid-bit -> load uart_data from the shift register, pulse uart_done for exactly one cycle, -> IDLE on the same edge.
REQ-021 STOP: majority 0 at mid-bit -> pulse frame_err for one cycle, keep uart_data unchanged, no uart_done, -> WAIT_HIGH.
REQ-022 WAIT_HIGH SHALL stay until rx_s=1, then -> IDLE; a held-low line (break) SHALL not generate further frames.
REQ-023 Returning to IDLE at mid-stop-bit SHALL allow a back-to-back frame whose start edge arrives from half a bit later on.
REQ-024 uart_done and frame_err SHALL never be high in the same cycle.
REQ-025 uart_data SHALL hold its value between uart_done pulses.
REQ-026 Latency: uart_done high 2 sync cycles plus ~9.5 bit periods after the line falling edge (±1 cycle).
REQ-027 Edges on uart_rxd in DATA/STOP other than at sample points SHALL be ignored.

Reset
REQ-028 On sys_rst_n low, SHALL immediately force: FSM IDLE, clk_cnt 0, bit index 0, shift register 0, synchronizer and rx_d to 1, uart_data 8'h00, uart_done 0, frame_err 0, uart_rx_busy 0.
REQ-029 Reset mid-frame SHALL abort the frame with no pulse; after release, reception SHALL resume at the next start edge.

Verification
REQ-030 Send 8'h55 at 115200 baud, 50 MHz: uart_done pulses once, uart_data = 8'h55, frame_err stays 0.
REQ-031 Send 8'hA3 then 8'h0F back-to-back (stop bit of 1 bit period): two uart_done pulses, data 8'hA3 then 8'h0F.
REQ-032 Low glitch of 100 cycles on idle line: FSM returns to IDLE, no uart_done, no frame_err.
REQ-033 Frame 8'h3C with stop bit driven low, line held low 20 bit periods then high: one frame_err pulse, uart_data unchanged, then 8'h81 received correctly.
REQ-034 Single-cycle glitch at a data bit's HALF sample point: majority vote recovers the correct byte.
REQ-035 Assert sys_rst_n low during bit 4 of a frame: all outputs go to reset values; next frame 8'hC6 received correctly.

Source files
------------

// File: rtl/uart_recv.sv
// UART receiver: 8N1 framing, LSB first, 3-sample majority vote at mid-bit.
// The serial input is double-registered before use. A third register
// provides falling-edge detection for the start bit. A low stop bit reports
// a framing error. After a framing error the receiver waits for the line to
// return high, so a held-low break produces only one error pulse.
module uart_recv #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err,
    output logic       uart_rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;

    // Counter values at which the bit-period counter wraps and samples the line
    localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_S0   = 16'(HALF - 1);
    localparam logic [15:0] CNT_S1   = 16'(HALF);
    localparam logic [15:0] CNT_VOTE = 16'(HALF + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t      state_reg;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_d;
    logic [15:0] clk_cnt;
    logic [15:0] cnt_next;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        smp0_reg;
    logic        smp1_reg;
    logic        vote;
    logic        vote_point;
    logic        cnt_wrap;
    logic        start_edge;

    // Two-stage synchronizer (rx_meta, rx_s) plus a delayed copy (rx_d) for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // Decode the counter phase and form the 2-of-3 vote from the two stored samples and the current one
    always_comb begin
        start_edge = rx_d & ~rx_s;
        cnt_wrap   = (clk_cnt == CNT_LAST);
        vote_point = (clk_cnt == CNT_VOTE);
        cnt_next   = cnt_wrap ? 16'd0 : clk_cnt + 16'd1;
        vote       = (smp0_reg & smp1_reg) | (smp0_reg & rx_s) | (smp1_reg & rx_s);
    end

    // Capture the first two of the three mid-bit samples
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            smp0_reg <= 1'b1;
            smp1_reg <= 1'b1;
        end else begin
            if (clk_cnt == CNT_S0) begin
                smp0_reg <= rx_s;
            end
            if (clk_cnt == CNT_S1) begin
                smp1_reg <= rx_s;
            end
        end
    end

    // Frame state machine with registered data and result pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
            clk_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            uart_data <= 8'h00;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            frame_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Hold the counter at zero so that START begins from a cleared count
                    clk_cnt <= 16'd0;
                    bit_idx <= 3'd0;
                    if (start_edge) begin
                        state_reg <= START;
                    end
                end
                START: begin
                    clk_cnt <= cnt_next;
                    if (vote_point && vote) begin
                        // The line went high again before mid-bit: treat it as a glitch
                        state_reg <= IDLE;
                        clk_cnt   <= 16'd0;
                    end else if (cnt_wrap) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    clk_cnt <= cnt_next;
                    if (vote_point) begin
                        shift_reg <= {vote, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                    end
                    // bit_idx returns to 0 only after the eighth sample has been taken
                    if (cnt_wrap && (bit_idx == 3'd0)) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    clk_cnt <= cnt_next;
                    if (vote_point) begin
                        // Leave at mid-stop-bit so that a back-to-back start edge is not missed
                        clk_cnt <= 16'd0;
                        if (vote) begin
                            uart_data <= shift_reg;
                            uart_done <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    clk_cnt <= 16'd0;
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    clk_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign uart_rx_busy = (state_reg != IDLE);

endmodule
